// File: rtl/fft_peak_pkg.sv
// Shared types and constants for the FFT peak finder and its bin-to-Hz converter.
package fft_peak_pkg;

    typedef enum logic [1:0] {
        StScan,
        StCalc,
        StReport
    } state_e;

    localparam int unsigned FFT_SIZE_DEFAULT = 1024;
    localparam int unsigned BIN_W            = $clog2(FFT_SIZE_DEFAULT);
    localparam int unsigned FREQ_W           = 16;
    localparam logic [FREQ_W-1:0] FREQ_MAX   = 16'hFFFF;

endpackage

// File: rtl/bin_to_hz.sv
// Registered conversion of an FFT bin index to Hz: (bin * SAMPLE_RATE) >> log2(FFT_SIZE),
// truncated and saturated to 16 bits. One cycle of latency when en is high.
module bin_to_hz
    import fft_peak_pkg::*;
#(
    parameter int unsigned FFT_SIZE    = 1024,
    parameter int unsigned SAMPLE_RATE = 100000
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        en,
    input  logic [$clog2(FFT_SIZE)-1:0] bin,
    output logic [FREQ_W-1:0]           freq
);

    logic [63:0]       prod;
    logic [63:0]       scaled;
    logic [FREQ_W-1:0] freq_sat;

    // 64 bits covers the largest bin times any 32-bit sample rate without overflow
    assign prod     = 64'(bin) * 64'(SAMPLE_RATE);
    assign scaled   = prod >> $clog2(FFT_SIZE);
    assign freq_sat = (scaled > 64'(FREQ_MAX)) ? FREQ_MAX : scaled[FREQ_W-1:0];

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            freq <= '0;
        end else if (en) begin
            freq <= freq_sat;
        end
    end

endmodule

// File: rtl/fft_peak_finder.sv
// Finds the largest-magnitude bin inside [MIN_BIN, MAX_BIN] of each streamed FFT frame and
// reports it in Hz. Optional FFT_PEAK_THRESH_EN gates the report on a minimum magnitude.
module fft_peak_finder
    import fft_peak_pkg::*;
#(
    parameter int unsigned FFT_SIZE    = 1024,
    parameter int unsigned SAMPLE_RATE = 100000,
    parameter int unsigned MAG_W       = 24,
    parameter int unsigned MIN_BIN     = 8,
    parameter int unsigned MAX_BIN     = 511,
    parameter int unsigned MAG_THRESH  = 4096
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic                        mag_tvalid,
    input  logic [MAG_W-1:0]            mag_tdata,
    input  logic                        mag_tlast,
    output logic                        mag_tready,
    output logic                        start_calc,
    output logic [FREQ_W-1:0]           peak_frequency,
    output logic [$clog2(FFT_SIZE)-1:0] peak_bin,
    output logic [MAG_W-1:0]            peak_magnitude,
    output logic                        frame_err,
    output logic                        no_target
);

    localparam int unsigned BinW = $clog2(FFT_SIZE);
    localparam logic [BinW-1:0] LastBin = BinW'(FFT_SIZE - 1);
    localparam logic [BinW-1:0] MinBin  = BinW'(MIN_BIN);
    localparam logic [BinW-1:0] MaxBin  = BinW'(MAX_BIN);

    state_e            state_q, state_d;
    logic [BinW-1:0]   cnt_q, cnt_d;
    logic [MAG_W-1:0]  max_q, max_d;
    logic [BinW-1:0]   best_q, best_d;
    logic              seen_q, seen_d;
    logic              full_q, full_d;
    logic              start_d, err_d, nt_d;
    logic [BinW-1:0]   pbin_d;
    logic [MAG_W-1:0]  pmag_d;
    logic [FREQ_W-1:0] pfreq_d;
    logic [FREQ_W-1:0] freq;
    logic              calc_en;
    logic              beat, in_win, upd, below_thresh;

    assign mag_tready = (state_q == StScan);
    assign beat       = mag_tvalid && mag_tready;
    assign in_win     = (cnt_q >= MinBin) && (cnt_q <= MaxBin);
    // Strict greater-than keeps the lower bin on ties
    assign upd        = beat && in_win && (!seen_q || (mag_tdata > max_q));

`ifdef FFT_PEAK_THRESH_EN
    assign below_thresh = (max_q < MAG_W'(MAG_THRESH));
`else
    logic unused_thresh;
    assign unused_thresh = ^32'(MAG_THRESH);
    assign below_thresh  = 1'b0;
`endif

    bin_to_hz #(
        .FFT_SIZE    (FFT_SIZE),
        .SAMPLE_RATE (SAMPLE_RATE)
    ) u_bin_to_hz (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .en     (calc_en),
        .bin    (best_q),
        .freq   (freq)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        best_d  = best_q;
        seen_d  = seen_q;
        full_d  = full_q;
        start_d = 1'b0;
        err_d   = 1'b0;
        nt_d    = 1'b0;
        pbin_d  = peak_bin;
        pmag_d  = peak_magnitude;
        pfreq_d = peak_frequency;
        calc_en = 1'b0;

        unique case (state_q)
            StScan: begin
                if (beat) begin
                    if (upd) begin
                        max_d  = mag_tdata;
                        best_d = cnt_q;
                        seen_d = 1'b1;
                    end
                    // Saturate on the last bin; full_q marks any later beat as overrun
                    if (cnt_q == LastBin) begin
                        full_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (mag_tlast) begin
                        if ((cnt_q == LastBin) && !full_q && (seen_q || upd)) begin
                            state_d = StCalc;
                        end else begin
                            err_d  = 1'b1;
                            cnt_d  = '0;
                            max_d  = '0;
                            best_d = '0;
                            seen_d = 1'b0;
                            full_d = 1'b0;
                        end
                    end
                end
            end
            StCalc: begin
                calc_en = 1'b1;
                state_d = StReport;
            end
            StReport: begin
                pbin_d  = best_q;
                pmag_d  = max_q;
                pfreq_d = freq;
                start_d = !below_thresh;
                nt_d    = below_thresh;
                cnt_d   = '0;
                max_d   = '0;
                best_d  = '0;
                seen_d  = 1'b0;
                full_d  = 1'b0;
                state_d = StScan;
            end
            default: state_d = StScan;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q        <= StScan;
            cnt_q          <= '0;
            max_q          <= '0;
            best_q         <= '0;
            seen_q         <= 1'b0;
            full_q         <= 1'b0;
            start_calc     <= 1'b0;
            frame_err      <= 1'b0;
            no_target      <= 1'b0;
            peak_bin       <= '0;
            peak_magnitude <= '0;
            peak_frequency <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            max_q          <= max_d;
            best_q         <= best_d;
            seen_q         <= seen_d;
            full_q         <= full_d;
            start_calc     <= start_d;
            frame_err      <= err_d;
            no_target      <= nt_d;
            peak_bin       <= pbin_d;
            peak_magnitude <= pmag_d;
            peak_frequency <= pfreq_d;
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Table-driven, scoreboarded bench for fft_peak_finder at default parameters.
module tb_fft_peak_finder;
    import fft_peak_pkg::*;

    localparam int KRep = 4;
    localparam int KErr = 2;
    localparam int KNt  = 1;

    logic              clk;
    logic              rst_in;
    logic              mag_tvalid;
    logic [23:0]       mag_tdata;
    logic              mag_tlast;
    logic              mag_tready;
    logic              start_calc;
    logic [15:0]       peak_frequency;
    logic [BIN_W-1:0]  peak_bin;
    logic [23:0]       peak_magnitude;
    logic              frame_err;
    logic              no_target;

    fft_peak_finder dut (
        .clk_in         (clk),
        .rst_in         (rst_in),
        .mag_tvalid     (mag_tvalid),
        .mag_tdata      (mag_tdata),
        .mag_tlast      (mag_tlast),
        .mag_tready     (mag_tready),
        .start_calc     (start_calc),
        .peak_frequency (peak_frequency),
        .peak_bin       (peak_bin),
        .peak_magnitude (peak_magnitude),
        .frame_err      (frame_err),
        .no_target      (no_target)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int a;
        int amag;
        int b;
        int bmag;
        int base;
        int last;
        int kind;
        int ebin;
        int efreq;
        int emag;
    } vec_t;

    typedef struct {
        int kind;
        int bin;
        int freq;
        int mag;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   errors;
    int   checks;
    int   held_bin, held_freq, held_mag;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one clock and inspect outputs on the falling edge
    task automatic cycle();
        exp_t e;
        int   kind_act;
        @(posedge clk);
        @(negedge clk);
        kind_act = {29'd0, start_calc, frame_err, no_target};
        if (kind_act != 0) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", kind_act, 0);
            end else begin
                e = sb.pop_front();
                check("strobe_kind", kind_act, e.kind);
                check("peak_bin", int'(peak_bin), e.bin);
                check("peak_frequency", int'(peak_frequency), e.freq);
                check("peak_magnitude", int'(peak_magnitude), e.mag);
            end
        end
    endtask

    task automatic send_beat(input int data, input bit last);
        bit ok;
        int tries;
        tries = 0;
        do begin
            mag_tvalid = 1'b1;
            mag_tdata  = 24'(data);
            mag_tlast  = last;
            ok         = mag_tready;
            cycle();
            tries++;
        end while (!ok && tries < 10);
        if (!ok) check("beat_accept_timeout", 0, 1);
        mag_tvalid = 1'b0;
        mag_tlast  = 1'b0;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        if (v.kind != KErr) begin
            held_bin  = v.ebin;
            held_freq = v.efreq;
            held_mag  = v.emag;
        end
        e.kind = v.kind;
        e.bin  = held_bin;
        e.freq = held_freq;
        e.mag  = held_mag;
        sb.push_back(e);
    endtask

    task automatic send_frame(input vec_t v);
        int r0, r1;
        push_exp(v);
        for (int i = 0; i <= v.last; i++) begin
            if ($urandom_range(0, 7) == 0) cycle();
            send_beat((i == v.a) ? v.amag : (i == v.b) ? v.bmag : v.base, i == v.last);
        end
        if (v.kind != KErr) begin
            r0 = int'(mag_tready);
            cycle();
            r1 = int'(mag_tready);
            cycle();
            check("tready_after_tlast", r0 * 100 + r1 * 10 + int'(mag_tready), 1);
        end
        repeat (4) cycle();
    endtask

    vec_t rv;
    int   kind_thresh;

    initial begin
        errors     = 0;
        checks     = 0;
        held_bin   = 0;
        held_freq  = 0;
        held_mag   = 0;
        rst_in     = 1'b0;
        mag_tvalid = 1'b0;
        mag_tdata  = '0;
        mag_tlast  = 1'b0;

`ifdef FFT_PEAK_THRESH_EN
        kind_thresh = KNt;
`else
        kind_thresh = KRep;
`endif
        //          a    amag   b    bmag base last  kind  bin  freq   mag
        vecs[0] = '{410, 1000,  -1,  0,   0,   1023, KRep, 410, 40039, 1000};
        vecs[1] = '{100, 5000,  200, 5000, 10, 1023, KRep, 100, 9765,  5000};
        vecs[2] = '{3,   99999, 50,  20,  0,   1023, KRep, 50,  4882,  20};
        vecs[3] = '{410, 1000,  -1,  0,   0,   500,  KErr, 0,   0,     0};
        vecs[4] = '{420, 777,   -1,  0,   1,   1023, KRep, 420, 41015, 777};
        vecs[5] = '{300, 4095,  -1,  0,   0,   1023, kind_thresh, 300, 29296, 4095};
        vecs[6] = '{301, 4096,  -1,  0,   0,   1023, KRep, 301, 29394, 4096};
        vecs[7] = '{200, 3000,  -1,  0,   0,   1024, KErr, 0,   0,     0};
        vecs[8] = '{512, 9000,  511, 50,  0,   1023, KRep, 511, 49902, 50};
        vecs[9] = '{7,   9000,  8,   60,  0,   1023, KRep, 8,   781,   60};

        repeat (2) cycle();
        rst_in = 1'b1;
        check("rst_tready", int'(mag_tready), 1);
        check("rst_start_calc", int'(start_calc), 0);
        check("rst_frame_err", int'(frame_err), 0);
        check("rst_no_target", int'(no_target), 0);
        check("rst_peak_bin", int'(peak_bin), 0);
        check("rst_peak_freq", int'(peak_frequency), 0);
        check("rst_peak_mag", int'(peak_magnitude), 0);

        for (int k = 0; k < 10; k++) send_frame(vecs[k]);

        // Reset in the middle of a frame, then a full frame must count from bin 0
        for (int i = 0; i < 300; i++) send_beat(5, 1'b0);
        rst_in = 1'b0;
        cycle();
        rst_in   = 1'b1;
        held_bin  = 0;
        held_freq = 0;
        held_mag  = 0;
        check("midrst_tready", int'(mag_tready), 1);
        check("midrst_peak_bin", int'(peak_bin), 0);
        check("midrst_peak_mag", int'(peak_magnitude), 0);
        rv = '{420, 1234, -1, 0, 2, 1023, KRep, 420, 41015, 1234};
        send_frame(rv);

        repeat (8) cycle();
        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
